// File: rtl/led_frame_buffer_pkg.sv
// rtl/led_frame_buffer_pkg.sv - shared address map and commit FSM encoding for the LED frame buffer
package led_frame_buffer_pkg;

  localparam logic [1:0] ADDR_FRAME_LO = 2'd0;
  localparam logic [1:0] ADDR_FRAME_HI = 2'd1;
  localparam logic [1:0] ADDR_MASK_LO  = 2'd2;
  localparam logic [1:0] ADDR_MASK_HI  = 2'd3;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } fb_state_t;

  // Replace the low or high byte of a 16-bit word.
  function automatic logic [15:0] set_byte(input logic [15:0] word, input logic hi,
                                           input logic [7:0] value);
    return hi ? {value, word[7:0]} : {word[15:8], value};
  endfunction

endpackage

// File: rtl/led_blink_prescaler.sv
// rtl/led_blink_prescaler.sv - free-running blink prescaler with a sticky toggle request
module led_blink_prescaler #(
  parameter int DIV_W = 20
) (
  input  logic i_CLK,
  input  logic i_RESET_n,
  input  logic i_Clear,
  output logic o_ToggleReq
);

  logic [DIV_W-1:0] count;
  logic             wrap;
  logic             toggle_req;

  assign wrap        = &count;
  assign o_ToggleReq = toggle_req;

  // A wrap coinciding with a clear wins, so no blink period is lost.
  always_ff @(posedge i_CLK) begin
    if (!i_RESET_n) begin
      count      <= '0;
      toggle_req <= 1'b0;
    end else begin
      count <= count + DIV_W'(1);
      if (wrap)
        toggle_req <= 1'b1;
      else if (i_Clear)
        toggle_req <= 1'b0;
    end
  end

endmodule

// File: rtl/led_frame_buffer.sv
// rtl/led_frame_buffer.sv - staged LED frame/blink mask, published to the serializer only at frame boundaries
module led_frame_buffer
  import led_frame_buffer_pkg::*;
#(
  parameter int BLINK_DIV_W = 20
) (
  input  logic        i_CLK,
  input  logic        i_RESET_n,
  input  logic        i_WrEn,
  input  logic [1:0]  i_WrAddr,
  input  logic [7:0]  i_WrData,
  input  logic        i_Commit,
  input  logic        i_FrameStart,
  output logic [15:0] o_Data16,
  output logic        o_Pending,
  output logic        o_CommitDone
);

  fb_state_t   state, next_state;
  logic        apply;
  logic [15:0] stage_frame, stage_mask;
  logic [15:0] active_frame, active_mask;
  logic [15:0] next_frame, next_mask;
  logic        blink_phase, next_phase;
  logic        toggle_req;
  logic [15:0] data16;
  logic        commit_done;

  led_blink_prescaler #(.DIV_W(BLINK_DIV_W)) u_prescaler (
    .i_CLK       (i_CLK),
    .i_RESET_n   (i_RESET_n),
    .i_Clear     (i_FrameStart),
    .o_ToggleReq (toggle_req)
  );

  always_comb begin
    next_state = state;
    apply      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_Commit) next_state = ST_PENDING;
      end
      ST_PENDING: begin
        if (i_FrameStart) begin
          apply      = 1'b1;
          next_state = i_Commit ? ST_PENDING : ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // The output register samples post-apply values so new data shows one clock after the boundary.
  assign next_frame = apply ? stage_frame : active_frame;
  assign next_mask  = apply ? stage_mask : active_mask;
  assign next_phase = blink_phase ^ (i_FrameStart & toggle_req);

  always_ff @(posedge i_CLK) begin
    if (!i_RESET_n) begin
      state        <= ST_IDLE;
      stage_frame  <= '0;
      stage_mask   <= '0;
      active_frame <= '0;
      active_mask  <= '0;
      blink_phase  <= 1'b0;
      data16       <= '0;
      commit_done  <= 1'b0;
    end else begin
      state        <= next_state;
      active_frame <= next_frame;
      active_mask  <= next_mask;
      blink_phase  <= next_phase;
      commit_done  <= apply;
      if (i_WrEn) begin
        case (i_WrAddr)
          ADDR_FRAME_LO: stage_frame <= set_byte(stage_frame, 1'b0, i_WrData);
          ADDR_FRAME_HI: stage_frame <= set_byte(stage_frame, 1'b1, i_WrData);
          ADDR_MASK_LO:  stage_mask  <= set_byte(stage_mask, 1'b0, i_WrData);
          default:       stage_mask  <= set_byte(stage_mask, 1'b1, i_WrData);
        endcase
      end
      if (i_FrameStart)
        data16 <= next_frame & ~(next_mask & {16{next_phase}});
    end
  end

  assign o_Data16     = data16;
  assign o_Pending    = (state == ST_PENDING);
  assign o_CommitDone = commit_done;

endmodule

// File: tb/tb_led_frame_buffer.sv
// tb/tb_led_frame_buffer.sv - randomized and directed self-checking bench for led_frame_buffer
module tb_led_frame_buffer;

  localparam int DIV_W  = 3;
  localparam int PERIOD = 1 << DIV_W;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        commit;
  logic        frame_start;
  logic [15:0] data16;
  logic        pending;
  logic        commit_done;

  int checks = 0;
  int errors = 0;

  led_frame_buffer #(.BLINK_DIV_W(DIV_W)) dut (
    .i_CLK        (clk),
    .i_RESET_n    (rst_n),
    .i_WrEn       (wr_en),
    .i_WrAddr     (wr_addr),
    .i_WrData     (wr_data),
    .i_Commit     (commit),
    .i_FrameStart (frame_start),
    .o_Data16     (data16),
    .o_Pending    (pending),
    .o_CommitDone (commit_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the driver should be showing, tracked per clock from the input rules.
  bit          m_valid = 0;
  logic [15:0] m_staged_frame, m_staged_mask, m_shown_frame, m_shown_mask, m_data;
  bit          m_pending, m_done, m_phase, m_req;
  int          m_ticks;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 1; m_staged_frame = 0; m_staged_mask = 0; m_shown_frame = 0;
      m_shown_mask = 0; m_data = 0; m_pending = 0; m_done = 0; m_phase = 0;
      m_req = 0; m_ticks = 0;
    end else if (m_valid) begin
      bit applies;
      applies = m_pending && frame_start;
      if (frame_start && m_req) begin
        m_phase = !m_phase;
        m_req   = 0;
      end
      if (m_ticks == PERIOD - 1) m_req = 1;
      m_ticks = (m_ticks + 1) % PERIOD;
      if (applies) begin
        m_shown_frame = m_staged_frame;
        m_shown_mask  = m_staged_mask;
      end
      if (wr_en) begin
        case (wr_addr)
          2'd0: m_staged_frame[7:0]  = wr_data;
          2'd1: m_staged_frame[15:8] = wr_data;
          2'd2: m_staged_mask[7:0]   = wr_data;
          2'd3: m_staged_mask[15:8]  = wr_data;
        endcase
      end
      m_pending = applies ? commit : (m_pending || commit);
      m_done    = applies;
      if (frame_start)
        m_data = m_phase ? (m_shown_frame & ~m_shown_mask) : m_shown_frame;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("data16", data16, m_data);
      check("pending", {15'd0, pending}, {15'd0, m_pending});
      check("commit_done", {15'd0, commit_done}, {15'd0, m_done});
    end
  end

  task automatic step(input bit w, input logic [1:0] a, input logic [7:0] d,
                      input bit c, input bit fs);
    wr_en = w; wr_addr = a; wr_data = d; commit = c; frame_start = fs;
    @(posedge clk); #1;
    wr_en = 0; commit = 0; frame_start = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  logic [15:0] seen [0:9];

  initial begin
    rst_n = 0; wr_en = 0; wr_addr = 0; wr_data = 0; commit = 0; frame_start = 0;

    // Reset with writes active: writes must be ignored.
    step(1, 2'd0, 8'hA5, 0, 0);
    step(1, 2'd1, 8'h3C, 0, 0);
    check("reset_data", data16, 16'h0000);
    check("reset_pending", {15'd0, pending}, 16'h0);
    rst_n = 1;
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    check("reset_writes_ignored", data16, 16'h0000);
    idle(2);

    // Basic write, commit, apply 5 clocks later.
    step(1, 2'd0, 8'hA5, 0, 0);
    step(1, 2'd1, 8'h3C, 1, 0);
    check("pending_after_commit", {15'd0, pending}, 16'h1);
    idle(4);
    check("data_held_before_fs", data16, 16'h0000);
    step(0, 0, 0, 0, 1);
    check("commit_applied", data16, 16'h3CA5);
    check("commit_done_pulse", {15'd0, commit_done}, 16'h1);
    idle(1);
    check("commit_done_single", {15'd0, commit_done}, 16'h0);

    // Commit and FrameStart in the same cycle do not apply.
    step(1, 2'd0, 8'h11, 0, 0);
    step(0, 0, 0, 1, 1);
    check("same_cycle_no_apply", data16, 16'h3CA5);
    check("same_cycle_pending", {15'd0, pending}, 16'h1);
    idle(2);
    step(0, 0, 0, 0, 1);
    check("next_fs_applies", data16, 16'h3C11);

    // A write in the applying cycle stays staged.
    step(0, 0, 0, 1, 0);
    idle(1);
    step(1, 2'd1, 8'hFF, 0, 1);
    check("write_on_apply_excluded", data16, 16'h3C11);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    check("write_applied_later", data16, 16'hFF11);

    // Blink: mask 00F0 over an all-ones frame, FrameStart every 4 clocks.
    step(1, 2'd0, 8'hFF, 0, 0);
    step(1, 2'd2, 8'hF0, 0, 0);
    step(1, 2'd3, 8'h00, 1, 0);
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 0, 0, 1);
      seen[k] = data16;
      if (k > 0) begin
        checks++;
        if (seen[k] !== 16'hFFFF && seen[k] !== 16'hFF0F) begin
          errors++;
          $display("FAIL blink_value: got %h expected FFFF or FF0F", seen[k]);
        end
      end
      if (k > 2) begin
        checks++;
        if (seen[k] === seen[k-2]) begin
          errors++;
          $display("FAIL blink_alternate: got %h twice, expected a toggle", seen[k]);
        end
      end
      idle(3);
    end

    // Reset while a commit is pending drops it.
    step(1, 2'd0, 8'h34, 0, 0);
    step(1, 2'd1, 8'h12, 1, 0);
    check("pending_before_reset", {15'd0, pending}, 16'h1);
    rst_n = 0;
    step(0, 0, 0, 0, 1);
    rst_n = 1;
    check("reset_drops_pending", {15'd0, pending}, 16'h0);
    idle(2);
    step(0, 0, 0, 0, 1);
    check("reset_no_commit_done", {15'd0, commit_done}, 16'h0);
    check("reset_data_after_fs", data16, 16'h0000);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      step($urandom_range(0, 9) < 3, 2'($urandom_range(0, 3)), 8'($urandom),
           $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
    end
    rst_n = 1;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
